// File: rtl/serial_mux_adder_pkg.sv
// Shared types and helpers for the bit-serial mux-based adder.
package serial_mux_adder_pkg;

    // Operation sequencing: wait for operands, ripple slices, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice counter; never narrower than one bit so a
    // single-step configuration still has a legal counter register.
    function automatic int step_cnt_w(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/fa_mux_cell.sv
// Single-bit full adder expressed purely as 2:1 mux selections.
module fa_mux_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate = a xor b, built as a mux on a choosing b or its inverse.
    // Sum flips ci when propagating; carry passes ci when propagating,
    // otherwise a (which equals b when not propagating) is the generate term.
    always_comb begin
        p  = a ? ~b : b;
        s  = p ? ~ci : ci;
        co = p ? ci : a;
    end

endmodule

// File: rtl/serial_mux_adder.sv
// Multi-cycle adder/subtractor: processes BITS_PER_CYCLE bits per cycle
// through a short ripple of mux-based full-adder cells, with a
// valid/ready handshake on both the operand and result sides.
module serial_mux_adder
    import serial_mux_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = step_cnt_w(STEPS);
    localparam int B     = BITS_PER_CYCLE;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;

    logic [B-1:0]     a_sl;
    logic [B-1:0]     b_sl;
    logic [B-1:0]     s_sl;
    logic [B:0]       c;
    int               idx;
    logic             last;

    assign last      = (cnt == CW'(STEPS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = carry_r;
    assign ovf       = ovf_r;

    // Select the operand slice addressed by the step counter.
    always_comb begin
        idx  = int'(cnt) * B;
        a_sl = a_r[idx +: B];
        b_sl = b_r[idx +: B];
    end

    // Carry ripple through B cells; the registered carry seeds the chain.
    assign c[0] = carry_r;
    for (genvar gi = 0; gi < B; gi++) begin : g_cell
        fa_mux_cell u_fa (
            .a  (a_sl[gi]),
            .b  (b_sl[gi]),
            .ci (c[gi]),
            .s  (s_sl[gi]),
            .co (c[gi+1])
        );
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode for the accept / ripple / present sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture in IDLE and one slice of sum/carry per RUN cycle.
    // Subtraction is folded in at capture: b is inverted and carry seeded to 1.
    // The overflow flag tracks the last cell's carry-in vs carry-out, so after
    // the final slice it reflects the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub ? 1'b1 : cin;
                        sum_r   <= '0;
                        ovf_r   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx +: B] <= s_sl;
                    carry_r         <= c[B];
                    ovf_r           <= c[B] ^ c[B-1];
                    cnt             <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mux_adder.sv
// Directed and randomized checks for serial_mux_adder across several
// WIDTH / BITS_PER_CYCLE configurations sharing one clock and reset.
module tb_serial_mux_adder;

    localparam int ND = 4;
    localparam int WS [ND] = '{8, 8, 16, 4};
    localparam int BS [ND] = '{1, 4, 4, 2};

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [ND];
    logic        out_ready_s [ND];
    logic        cin_s       [ND];
    logic        sub_s       [ND];
    logic [15:0] a_s         [ND];
    logic [15:0] b_s         [ND];
    logic        in_ready_w  [ND];
    logic        out_valid_w [ND];
    logic        cout_w      [ND];
    logic        ovf_w       [ND];
    logic [15:0] sum_w       [ND];

    int checks = 0;
    int passed = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W-1:0] s;
        serial_mux_adder #(.WIDTH(W), .BITS_PER_CYCLE(BS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_w[g]),
            .a         (a_s[g][W-1:0]),
            .b         (b_s[g][W-1:0]),
            .cin       (cin_s[g]),
            .sub       (sub_s[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready_s[g]),
            .sum       (s),
            .cout      (cout_w[g]),
            .ovf       (ovf_w[g])
        );
        assign sum_w[g] = 16'(s);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: plain integer addition with two's-complement overflow rule.
    task automatic ref_model(input int w, input logic [15:0] av, bv, input logic ci, sb,
                             output logic [15:0] s, output logic co, ov);
        longint mask, aa, bb, full;
        mask = (64'd1 << w) - 1;
        aa   = longint'(av) & mask;
        bb   = sb ? (~longint'(bv)) & mask : longint'(bv) & mask;
        full = aa + bb + (sb ? 1 : longint'(ci));
        s    = 16'(full & mask);
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    endtask

    // One complete transaction: accept, scramble inputs, wait for result,
    // hold out_ready low for 'hold' cycles, then release.
    task automatic do_op(input int d, input logic [15:0] av, bv, input logic ci, sb,
                         input int hold, output logic [15:0] s, output logic co, ov,
                         output int lat);
        chk("ready_before_accept", 64'(in_ready_w[d]), 64'd1);
        a_s[d] = av; b_s[d] = bv; cin_s[d] = ci; sub_s[d] = sb;
        in_valid_s[d] = 1'b1;
        tick();
        in_valid_s[d] = 1'b0;
        a_s[d] = ~av; b_s[d] = bv ^ 16'h5A5A; cin_s[d] = ~ci; sub_s[d] = ~sb;
        lat = 0;
        while (!out_valid_w[d] && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid_w[d]) chk("result_timeout", 64'd0, 64'd1);
        s = sum_w[d]; co = cout_w[d]; ov = ovf_w[d];
        for (int i = 0; i < hold; i++) begin
            out_ready_s[d] = 1'b0;
            tick();
            if (out_valid_w[d] !== 1'b1 || sum_w[d] !== s) chk("hold_stable", 64'(sum_w[d]), 64'(s));
        end
        out_ready_s[d] = 1'b1;
        tick();
        out_ready_s[d] = 1'b0;
        in_valid_s[d]  = 1'b0;
    endtask

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [15:0] s, es;
        logic        co, ov, eco, eov;
        int          lat, d, t1, t2, t3, seen;
        string       nm;

        vecs[0] = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
        vecs[2] = '{0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0};
        vecs[3] = '{1, 16'h003C, 16'h000F, 1'b1, 1'b0, 16'h004C, 1'b0, 1'b0};
        vecs[4] = '{0, 16'h0080, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1};
        vecs[6] = '{2, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{3, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1};
        vecs[8] = '{1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0};
        vecs[9] = '{2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        for (int i = 0; i < ND; i++) begin
            in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
            cin_s[i] = 1'b0; sub_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
        end

        // Reset state, with in_valid asserted to show reset dominates.
        rst_n = 1'b0;
        in_valid_s[0] = 1'b1; a_s[0] = 16'h00AA; b_s[0] = 16'h0055;
        tick(); tick();
        rst_n = 1'b1;
        in_valid_s[0] = 1'b0;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst_in_ready_%0d", i), 64'(in_ready_w[i]), 64'd1);
            chk($sformatf("rst_out_valid_%0d", i), 64'(out_valid_w[i]), 64'd0);
            chk($sformatf("rst_sum_%0d", i), 64'(sum_w[i]), 64'd0);
            chk($sformatf("rst_cout_%0d", i), 64'(cout_w[i]), 64'd0);
            chk($sformatf("rst_ovf_%0d", i), 64'(ovf_w[i]), 64'd0);
        end

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, s, co, ov, lat);
            chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WS[vecs[i].d] / BS[vecs[i].d]));
            chk($sformatf("vec%0d_idle_after", i), 64'(in_ready_w[vecs[i].d]), 64'd1);
        end

        // Backpressure: five cycles of out_ready=0 with stray in_valid pulses.
        a_s[0] = 16'h0012; b_s[0] = 16'h0034; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        lat = 0;
        while (!out_valid_w[0] && lat < 40) begin tick(); lat++; end
        chk("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid_s[0] = i[0]; a_s[0] = 16'h0011; b_s[0] = 16'h0022;
            tick();
            chk($sformatf("bp_out_valid_%0d", i), 64'(out_valid_w[0]), 64'd1);
            chk($sformatf("bp_sum_%0d", i), 64'(sum_w[0]), 64'h46);
            chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready_w[0]), 64'd0);
        end
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b1;
        tick();
        out_ready_s[0] = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready_w[0]), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid_w[0]), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid_w[0] || !in_ready_w[0]) seen++;
        end
        chk("bp_no_phantom_op", 64'(seen), 64'd0);

        // Reset while RUN is at step 3: operation aborted, no result ever shown.
        a_s[0] = 16'h00F0; b_s[0] = 16'h000F; cin_s[0] = 1'b1; sub_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", 64'(in_ready_w[0]), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(in_ready_w[0]), 64'd1);
        chk("abort_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("abort_sum", 64'(sum_w[0]), 64'd0);
        chk("abort_cout", 64'(cout_w[0]), 64'd0);
        chk("abort_ovf", 64'(ovf_w[0]), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid_w[0]) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        do_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 0, s, co, ov, lat);
        chk("post_abort_sum", 64'(s), 64'h30);
        chk("post_abort_cout", 64'(co), 64'd0);

        // Back-to-back on the 4-bit-slice instance: period STEPS+2 = 4.
        a_s[1] = 16'h003C; b_s[1] = 16'h000F; cin_s[1] = 1'b1; sub_s[1] = 1'b0;
        in_valid_s[1] = 1'b1; out_ready_s[1] = 1'b1;
        t1 = -1; t2 = -1; t3 = -1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (out_valid_w[1]) begin
                chk($sformatf("b2b_sum_c%0d", i), 64'(sum_w[1]), 64'h4C);
                if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i; else if (t3 < 0) t3 = i;
            end
        end
        in_valid_s[1] = 1'b0;
        tick(); tick(); tick(); tick();
        out_ready_s[1] = 1'b0;
        chk("b2b_first", 64'(t1), 64'd3);
        chk("b2b_period1", 64'(t2 - t1), 64'd4);
        chk("b2b_period2", 64'(t3 - t2), 64'd4);

        // Randomized operations against the reference model.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] av, bv;
            logic        ci, sb;
            d  = $urandom_range(0, ND - 1);
            av = 16'($urandom);
            bv = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            av = av & 16'((32'd1 << WS[d]) - 1);
            bv = bv & 16'((32'd1 << WS[d]) - 1);
            ref_model(WS[d], av, bv, ci, sb, es, eco, eov);
            do_op(d, av, bv, ci, sb, $urandom_range(0, 3), s, co, ov, lat);
            nm = $sformatf("rnd%0d_w%0d_b%0d_%0h%s%0h", n, WS[d], BS[d], av, sb ? "-" : "+", bv);
            chk({nm, "_sum"}, 64'(s), 64'(es));
            chk({nm, "_cout"}, 64'(co), 64'(eco));
            chk({nm, "_ovf"}, 64'(ov), 64'(eov));
            chk({nm, "_lat"}, 64'(lat), 64'(WS[d] / BS[d]));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
